uart_receiver: RTL and testbench

//  Serial-to-parallel UART receiver, 8N1 framing, LSB first, oversampled on the

---
 rtl/uart_receiver.sv | 108 ++++++++++
 tb/tb_uart_receiver.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 LSB-first oversampled UART receiver with valid/read handshake and sticky error flags
module uart_receiver #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_rx,
    input  logic                 i_rd,
    input  logic                 i_clr_err,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_valid,
    output logic                 o_busy,
    output logic                 o_frame_err,
    output logic                 o_overrun
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] LAST = IW'(DATA_BITS - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

    state_t               state_q, state_d;
    logic                 sync1_q, sync1_d, rx_s_q, rx_s_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d, data_q, data_d;
    logic                 valid_q, valid_d, ferr_q, ferr_d, ovr_q, ovr_d;
    logic                 load, ferr_set;

    always_comb begin
        sync1_d  = i_rx;
        rx_s_d   = sync1_q;
        state_d  = state_q;
        cnt_d    = cnt_q + CW'(1);
        idx_d    = idx_q;
        shift_d  = shift_q;
        load     = 1'b0;
        ferr_set = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rx_s_q) state_d = S_START;
            end
            S_START: if (cnt_q == HALF) begin
                cnt_d   = '0;
                idx_d   = '0;
                state_d = rx_s_q ? S_IDLE : S_DATA;
            end
            S_DATA: if (cnt_q == FULL) begin
                cnt_d          = '0;
                shift_d[idx_q] = rx_s_q;
                idx_d          = idx_q + IW'(1);
                if (idx_q == LAST) state_d = S_STOP;
            end
            S_STOP: if (cnt_q == FULL) begin
                cnt_d    = '0;
                load     = rx_s_q;
                ferr_set = !rx_s_q;
                state_d  = rx_s_q ? S_IDLE : S_BREAK;
            end
            S_BREAK: begin
                cnt_d = '0;
                if (rx_s_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // A load in the same cycle as a read keeps the byte valid and is not an overrun
        data_d  = load ? shift_q : data_q;
        valid_d = load ? 1'b1 : (i_rd ? 1'b0 : valid_q);
        ovr_d   = (load && valid_q && !i_rd) ? 1'b1 : (i_clr_err ? 1'b0 : ovr_q);
        ferr_d  = ferr_set ? 1'b1 : (i_clr_err ? 1'b0 : ferr_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sync1_q <= sync1_d;
            rx_s_q  <= rx_s_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign o_data      = data_q;
    assign o_valid     = valid_q;
    assign o_busy      = (state_q != S_IDLE);
    assign o_frame_err = ferr_q;
    assign o_overrun   = ovr_q;
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed and randomized frames against a transaction-level receiver model
module tb_uart_receiver;
    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_rx = 1'b1;
    logic       i_rd = 1'b0;
    logic       i_clr_err = 1'b0;
    logic [7:0] o_data;
    logic       o_valid, o_busy, o_frame_err, o_overrun;

    int tests = 0;
    int fails = 0;

    logic [7:0] m_data = 8'h00;
    logic       m_valid = 1'b0, m_ferr = 1'b0, m_ovr = 1'b0;

    uart_receiver #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
        .clk(clk), .rst(rst), .i_rx(i_rx), .i_rd(i_rd), .i_clr_err(i_clr_err),
        .o_data(o_data), .o_valid(o_valid), .o_busy(o_busy),
        .o_frame_err(o_frame_err), .o_overrun(o_overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, "_data"}, 32'(o_data), 32'(m_data));
        chk({tag, "_valid"}, 32'(o_valid), 32'(m_valid));
        chk({tag, "_ferr"}, 32'(o_frame_err), 32'(m_ferr));
        chk({tag, "_ovr"}, 32'(o_overrun), 32'(m_ovr));
    endtask

    task automatic idle(input int n);
        i_rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bit(input logic b);
        i_rx = b;
        repeat (CPB) @(negedge clk);
    endtask

    // Stop-bit loop iteration c passes the (145+c)th edge since the start bit; the load edge is the 155th
    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input bit rd_at_load, input string tag);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            drive_bit(d[i]);
            if (i == 3) chk({tag, "_busy_mid"}, 32'(o_busy), 32'd1);
        end
        i_rx = stop_bit;
        for (int c = 0; c < CPB; c++) begin
            i_rd = rd_at_load && (c == 10);
            @(negedge clk);
            if (c == 9) chk({tag, "_valid_pre_edge155"}, 32'(o_valid), 32'(m_valid));
            if (c == 10) begin
                if (stop_bit) begin
                    if (m_valid && !rd_at_load) m_ovr = 1'b1;
                    m_valid = 1'b1;
                    m_data  = d;
                end else m_ferr = 1'b1;
                chk_all({tag, "_edge155"});
            end
        end
        i_rd = 1'b0;
    endtask

    task automatic read_byte(input string tag);
        i_rd = 1'b1;
        @(negedge clk);
        i_rd = 1'b0;
        m_valid = 1'b0;
        chk_all(tag);
    endtask

    task automatic clr_err(input string tag);
        i_clr_err = 1'b1;
        @(negedge clk);
        i_clr_err = 1'b0;
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
        chk_all(tag);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        i_rx = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_data = 8'h00; m_valid = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        do_reset();
        chk_all("reset");
        chk("reset_busy", 32'(o_busy), 32'd0);
        idle(5);

        send_frame(8'hA5, 1'b1, 1'b0, "t1_a5");
        read_byte("t1_read");

        i_rx = 1'b0;
        repeat (4) @(negedge clk);
        chk("t2_busy_pulse", 32'(o_busy), 32'd1);
        idle(20);
        chk("t2_busy_back", 32'(o_busy), 32'd0);
        chk_all("t2_glitch");

        do_reset();
        idle(5);
        send_frame(8'h3C, 1'b0, 1'b0, "t3_bad_stop");
        i_rx = 1'b0;
        repeat (3 * CPB) @(negedge clk);
        chk("t3_busy_break", 32'(o_busy), 32'd1);
        i_rx = 1'b1;
        repeat (4) @(negedge clk);
        chk("t3_busy_release", 32'(o_busy), 32'd0);
        clr_err("t3_clr");

        send_frame(8'h11, 1'b1, 1'b0, "t4_11");
        send_frame(8'h22, 1'b1, 1'b0, "t4_22_ovr");
        read_byte("t4_read");
        clr_err("t4_clr");
        send_frame(8'h11, 1'b1, 1'b0, "t4b_11");
        send_frame(8'h22, 1'b1, 1'b1, "t4b_22_rd");
        idle(4);

        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(8'h5A >> i);
        do_reset();
        chk_all("t5_reset");
        chk("t5_busy", 32'(o_busy), 32'd0);
        idle(2 * CPB);
        send_frame(8'h5A, 1'b1, 1'b0, "t5_5a");

        for (int n = 0; n < 12; n++) begin
            logic [7:0] d;
            logic       good;
            d    = 8'($urandom);
            good = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 1) == 1) read_byte("rnd_read");
            if ($urandom_range(0, 3) == 0) clr_err("rnd_clr");
            send_frame(d, good, ($urandom_range(0, 3) == 0), "rnd_frame");
            idle(4 + $urandom_range(0, 20));
            chk("rnd_busy_idle", 32'(o_busy), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
